multicycle_adder: RTL

Parametrised, clocked successor to the gate-level full adder. It adds two WIDTH-bit operands plus carry-in over WIDTH/SLICE cycles, SLICE bits per cycle, using a registered ripple carry between slices. Operands arrive and results leave on valid/ready handshakes. The block sits in the datapath examples as the reusable sequential adder for coverage benches.

---
 rtl/adder_pkg.sv | 19 +
 rtl/multicycle_adder_if.sv | 37 +++
 rtl/adder_slice.sv | 29 ++
 rtl/multicycle_adder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and defaults for multicycle_adder (ADDER_SUB_EN adds subtract)
package adder_pkg;

   localparam int STATE_W       = 2;
   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_SLICE = 4;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // One full-adder cell: {carry, sum}
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
      return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
   endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// rtl/multicycle_adder_if.sv - operand/result handshake bundle; sub member exists only with ADDER_SUB_EN
interface multicycle_adder_if
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef ADDER_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
`ifdef ADDER_SUB_EN
      output sub,
`endif
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
`ifdef ADDER_SUB_EN
      input  sub,
`endif
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

endinterface

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational SLICE-bit ripple of full-adder cells
module adder_slice
   import adder_pkg::*;
#(
   parameter int SLICE = DEFAULT_SLICE
) (
   input  logic [SLICE-1:0] a_s,
   input  logic [SLICE-1:0] b_s,
   input  logic             c_in,
   output logic [SLICE-1:0] s,
   output logic             c_out,
   output logic             c_msb_in
);
   logic [SLICE:0] c;

   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = c_in;
      for (int i = 0; i < SLICE; i++) begin
         {c[i+1], s[i]} = full_add(a_s[i], b_s[i], c[i]);
      end
   end

   assign c_out    = c[SLICE];
   // Carry into the top bit of this slice; only meaningful for the MSB slice
   assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - sequential adder, SLICE bits per cycle; ADDER_SUB_EN enables subtract
module multicycle_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SLICE = DEFAULT_SLICE
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_adder_if.slave bus
);
   localparam int NS = WIDTH / SLICE;
   localparam int KW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

   generate
      if ((WIDTH % SLICE) != 0) begin : g_bad_cfg
         $error("multicycle_adder: WIDTH must be a multiple of SLICE");
      end
   endgenerate

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] sum_r;
   logic             carry;
   logic             cout_r;
   logic             ovf_r;
   logic [KW-1:0]    k;
   logic             sub_req;
   logic             in_ready;
   logic             out_valid;

   logic [SLICE-1:0] s_a;
   logic [SLICE-1:0] s_b;
   logic [SLICE-1:0] s_sum;
   logic             s_cout;
   logic             s_cmsb;

`ifdef ADDER_SUB_EN
   assign sub_req = bus.sub;
`else
   assign sub_req = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_nx = CALC;
         end
         CALC: begin
            if (k == K_LAST) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign s_a = opa[int'(k) * SLICE +: SLICE];
   assign s_b = opb[int'(k) * SLICE +: SLICE];

   adder_slice #(.SLICE(SLICE)) u_slice (
      .a_s      (s_a),
      .b_s      (s_b),
      .c_in     (carry),
      .s        (s_sum),
      .c_out    (s_cout),
      .c_msb_in (s_cmsb)
   );

   // Subtract is a + ~b + 1: invert b and force the carry-in at acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         opa    <= '0;
         opb    <= '0;
         sum_r  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         k      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  opa   <= bus.a;
                  opb   <= sub_req ? ~bus.b : bus.b;
                  carry <= sub_req | bus.cin;
                  k     <= '0;
               end
            end
            CALC: begin
               sum_r[int'(k) * SLICE +: SLICE] <= s_sum;
               carry <= s_cout;
               if (k == K_LAST) begin
                  cout_r <= s_cout;
                  ovf_r  <= s_cout ^ s_cmsb;
                  k      <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;
   assign bus.ovf       = ovf_r;

endmodule
